// File: rtl/approx_adder_err_accum.sv
// approx_adder_err_accum
//
// Streaming error-metric accumulator for 16-bit approximate adders. Each
// accepted sample carries both operands and the approximate adder's sum. The
// block recomputes the exact sum, takes the absolute error, and accumulates
// run statistics over num_samples samples. It then raises done and holds the
// results until the next start.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begins a run; honoured only in IDLE or DONE
//   num_samples        run length, latched on an accepted start
//   in_valid/in_ready  sample handshake; in_ready never depends on in_valid
//   op_a, op_b         operands applied to the approximate adder
//   approx_sum         approximate adder output (MSB = carry-out)
//   busy               high while running or draining the pipeline
//   done               high when the results are final and stable
//   sample_cnt         samples accumulated
//   err_cnt            samples with non-zero error
//   err_sum            saturating sum of absolute errors
//   err_max            largest absolute error seen
//   err_max_idx        0-based index of the first sample reaching err_max

module approx_adder_err_accum #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [WIDTH:0]   err_max,
  output logic [CNT_W-1:0] err_max_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] accepted;

  // stage-1 pipeline registers
  logic             s1_valid;
  logic [WIDTH:0]   s1_exact;
  logic [WIDTH:0]   s1_approx;
  logic [CNT_W-1:0] s1_idx;

  logic             start_ok;
  logic             accept;
  logic             last_accept;
  logic [WIDTH:0]   err_mag;
  logic [ACC_W:0]   sum_ext;

  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign in_ready    = (state == RUN) && (accepted < n_lat);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (accepted == (n_lat - CNT_W'(1)));

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // Magnitude of the signed (WIDTH+2)-bit difference, formed by ordering the
  // operands so the subtraction can never go negative.
  always_comb begin
    err_mag = '0;
    if (s1_exact >= s1_approx) begin
      err_mag = s1_exact - s1_approx;
    end else begin
      err_mag = s1_approx - s1_exact;
    end
  end

  // One extra bit catches overflow. Once err_sum is all-ones, any non-zero
  // error overflows again, so the saturated value is sticky for the run.
  assign sum_ext = {1'b0, err_sum} + (ACC_W+1)'(err_mag);

  // ------------------------------------------------------------------
  // state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // the final sample sits in stage 1 for one cycle after acceptance
        if (!s1_valid) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // run length and acceptance counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat    <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      n_lat    <= num_samples;
      accepted <= '0;
    end else if (accept) begin
      accepted <= accepted + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // stage 1: exact sum, captured approximate sum and sample index
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
      s1_idx    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact  <= {1'b0, op_a} + {1'b0, op_b};
        s1_approx <= approx_sum;
        s1_idx    <= accepted;
      end
    end
  end

  // ------------------------------------------------------------------
  // stage 2: accumulators
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      err_max_idx <= '0;
    end else if (start_ok) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      err_max_idx <= '0;
    end else if (s1_valid) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (err_mag != '0) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (sum_ext[ACC_W]) begin
        err_sum <= '1;
      end else begin
        err_sum <= sum_ext[ACC_W-1:0];
      end
      // strict compare: on a tie the earlier index is kept
      if (err_mag > err_max) begin
        err_max     <= err_mag;
        err_max_idx <= s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_err_accum.sv
module tb_approx_adder_err_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2;
  logic [31:0] num_samples;
  logic        in_valid;
  logic [15:0] op_a, op_b;
  logic [16:0] approx_sum;

  logic        in_ready1, busy1, done1;
  logic [31:0] sample_cnt1, err_cnt1, err_max_idx1;
  logic [47:0] err_sum1;
  logic [16:0] err_max1;

  logic        in_ready2, busy2, done2;
  logic [31:0] sample_cnt2, err_cnt2, err_max_idx2;
  logic [16:0] err_sum2;
  logic [16:0] err_max2;

  always #5 clk = ~clk;

  approx_adder_err_accum #(.WIDTH(16), .CNT_W(32), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready1), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy1), .done(done1),
    .sample_cnt(sample_cnt1), .err_cnt(err_cnt1), .err_sum(err_sum1),
    .err_max(err_max1), .err_max_idx(err_max_idx1)
  );

  // narrow accumulator instance for the saturation case
  approx_adder_err_accum #(.WIDTH(16), .CNT_W(32), .ACC_W(17)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready2), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy2), .done(done2),
    .sample_cnt(sample_cnt2), .err_cnt(err_cnt2), .err_sum(err_sum2),
    .err_max(err_max2), .err_max_idx(err_max_idx2)
  );

  logic        sel;
  logic        o_ready, o_busy, o_done;
  logic [31:0] o_scnt, o_ecnt, o_eidx;
  logic [47:0] o_esum;
  logic [16:0] o_emax;

  assign o_ready = sel ? in_ready2 : in_ready1;
  assign o_busy  = sel ? busy2 : busy1;
  assign o_done  = sel ? done2 : done1;
  assign o_scnt  = sel ? sample_cnt2 : sample_cnt1;
  assign o_ecnt  = sel ? err_cnt2 : err_cnt1;
  assign o_eidx  = sel ? err_max_idx2 : err_max_idx1;
  assign o_esum  = sel ? {31'd0, err_sum2} : err_sum1;
  assign o_emax  = sel ? err_max2 : err_max1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] s;
  } smp_t;

  typedef struct {
    logic        sel;
    int          n;
    int          first;
    logic [31:0] ecnt;
    logic [47:0] esum;
    logic [16:0] emax;
    logic [31:0] eidx;
  } run_t;

  smp_t smp [16];
  run_t runs [6];

  int n_vec = 0;
  int n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [31:0] scnt, input logic [31:0] ecnt,
                             input logic [47:0] esum, input logic [16:0] emax,
                             input logic [31:0] eidx);
    chk({tag, " sample_cnt"},  64'(o_scnt), 64'(scnt));
    chk({tag, " err_cnt"},     64'(o_ecnt), 64'(ecnt));
    chk({tag, " err_sum"},     64'(o_esum), 64'(esum));
    chk({tag, " err_max"},     64'(o_emax), 64'(emax));
    chk({tag, " err_max_idx"}, 64'(o_eidx), 64'(eidx));
  endtask

  task automatic pulse_start(input logic which, input int n);
    sel         = which;
    num_samples = 32'(n);
    start1      = !which;
    start2      = which;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic do_run(input int r);
    string tag;
    int    lat;
    tag = $sformatf("run%0d", r);
    pulse_start(runs[r].sel, runs[r].n);
    chk({tag, " busy"}, 64'(o_busy), 64'd1);
    for (int i = 0; i < runs[r].n; i++) begin
      in_valid   = 1'b1;
      op_a       = smp[runs[r].first + i].a;
      op_b       = smp[runs[r].first + i].b;
      approx_sum = smp[runs[r].first + i].s;
      chk($sformatf("%s in_ready s%0d", tag, i), 64'(o_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    lat = 0;
    while (!o_done && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, " done latency"}, 64'(lat), 64'd2);
    chk_results(tag, 32'(runs[r].n), runs[r].ecnt, runs[r].esum, runs[r].emax, runs[r].eidx);
  endtask

  initial begin
    // sample table
    smp[0]  = '{16'h0001, 16'h0002, 17'h00003};
    smp[1]  = '{16'hFFFF, 16'h0001, 17'h10000};
    smp[2]  = '{16'h0000, 16'h0000, 17'h00000};
    smp[3]  = '{16'h8000, 16'h8000, 17'h10000};
    smp[4]  = '{16'h00FF, 16'h0001, 17'h00000};  // err 0x100
    smp[5]  = '{16'h0FFF, 16'h0001, 17'h01000};  // err 0
    smp[6]  = '{16'h0123, 16'h0456, 17'h00000};  // err 0x579
    smp[7]  = '{16'h0000, 16'h0000, 17'h00010};  // err 16 (over)
    smp[8]  = '{16'h0008, 16'h0008, 17'h00000};  // err 16 (under)
    smp[9]  = '{16'h0000, 16'h0000, 17'h00010};  // err 16
    smp[10] = '{16'h0010, 16'h0000, 17'h00012};  // err 2
    smp[11] = '{16'hFFFF, 16'hFFFF, 17'h00000};  // err 0x1FFFE
    smp[12] = '{16'h0000, 16'h0000, 17'h0FFFF};  // err 0xFFFF
    smp[13] = '{16'h0000, 16'h0000, 17'h1FFFF};  // err 0x1FFFF
    smp[14] = '{16'h0000, 16'h0000, 17'h1FFFF};
    smp[15] = '{16'h0000, 16'h0000, 17'h1FFFF};

    // run table: sel, n, first, err_cnt, err_sum, err_max, err_max_idx
    runs[0] = '{1'b0, 2,  4, 32'd1, 48'h100,   17'h100,   32'd0};
    runs[1] = '{1'b0, 4,  0, 32'd0, 48'h0,     17'h0,     32'd0};
    runs[2] = '{1'b0, 3,  4, 32'd2, 48'h679,   17'h579,   32'd2};
    runs[3] = '{1'b0, 3,  7, 32'd3, 48'd48,    17'd16,    32'd0};
    runs[4] = '{1'b0, 3, 10, 32'd3, 48'h2FFFF, 17'h1FFFE, 32'd1};
    runs[5] = '{1'b1, 3, 13, 32'd3, 48'h1FFFF, 17'h1FFFF, 32'd0};

    sel = 1'b0;
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    approx_sum = '0;

    // reset state
    #12;
    chk("reset in_ready", 64'(in_ready1), 64'd0);
    chk("reset busy", 64'(busy1), 64'd0);
    chk("reset done", 64'(done1), 64'd0);
    chk_results("reset", 32'd0, 32'd0, 48'd0, 17'd0, 32'd0);
    rst_n = 1'b1;
    tick();

    // asynchronous reset after 3 of 10 samples
    pulse_start(1'b0, 10);
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      op_a       = smp[4 + i].a;
      op_b       = smp[4 + i].b;
      approx_sum = smp[4 + i].s;
      tick();
    end
    chk("midrun sample_cnt before reset", 64'(sample_cnt1), 64'd2);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrun in_ready", 64'(in_ready1), 64'd0);
    chk("midrun busy", 64'(busy1), 64'd0);
    chk("midrun done", 64'(done1), 64'd0);
    chk_results("midrun", 32'd0, 32'd0, 48'd0, 17'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset busy", 64'(busy1), 64'd0);

    for (int r = 0; r < 5; r++) begin
      do_run(r);
    end

    // handshake: in_valid 1,0,1,1 with N=2; start during DRAIN ignored
    pulse_start(1'b0, 2);
    in_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0001; approx_sum = 17'h00002;
    chk("hs ready c1", 64'(in_ready1), 64'd1);
    tick();
    in_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000; approx_sum = 17'h1FFFF;
    tick();
    in_valid = 1'b1; op_a = 16'h0002; op_b = 16'h0002; approx_sum = 17'h00005;
    chk("hs ready c3", 64'(in_ready1), 64'd1);
    tick();
    in_valid = 1'b1; op_a = 16'h0000; op_b = 16'h0000; approx_sum = 17'h1FFFF;
    chk("hs ready c4", 64'(in_ready1), 64'd0);
    start1 = 1'b1;
    num_samples = 32'd5;
    tick();
    start1 = 1'b0;
    in_valid = 1'b0;
    chk("hs done k+1", 64'(done1), 64'd0);
    chk("hs busy k+1", 64'(busy1), 64'd1);
    tick();
    chk("hs done k+2", 64'(done1), 64'd1);
    chk_results("hs", 32'd2, 32'd1, 48'd1, 17'd1, 32'd1);

    // N=0 on the wide instance, starting from non-zero results
    pulse_start(1'b0, 0);
    chk("n0 done", 64'(done1), 64'd1);
    chk("n0 busy", 64'(busy1), 64'd0);
    chk_results("n0", 32'd0, 32'd0, 48'd0, 17'd0, 32'd0);

    // saturation on the 17-bit accumulator, then N=0 clears it
    do_run(5);
    pulse_start(1'b1, 0);
    chk("sat n0 done", 64'(done2), 64'd1);
    chk_results("sat n0", 32'd0, 32'd0, 48'd0, 17'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
